// File: rtl/yarvi_wb.sv
// Write-back and restart stage: commits ME results to the register file,
// retires instructions, and redirects fetch on traps and load-hit-store.
module yarvi_wb #(
  parameter logic [31:0] RESET_PC     = 32'h8000_0000,
  parameter logic [31:0] MTVEC        = 32'h8000_0100,
  parameter int          FLUSH_CYCLES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        me_valid,
  input  logic [31:0] me_pc,
  input  logic [4:0]  me_wb_rd,
  input  logic [31:0] me_wb_val,
  input  logic        me_exc_misaligned,
  input  logic        me_exc_store,
  input  logic [31:0] me_exc_mtval,
  input  logic        me_load_hit_store,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val,
  output logic        restart,
  output logic [31:0] restart_pc,
  output logic        flush,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic [31:0] mtval,
  output logic [63:0] minstret,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_val
);

  localparam int FW = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [FW-1:0] FLOAD = FW'(FLUSH_CYCLES - 1);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  state_t        state;
  logic [FW-1:0] fcnt;
  logic [31:0]   rf [32];

  logic run;
  logic commit;

  assign run    = (state == RUN) && !reset;
  assign commit = run && !me_exc_misaligned && !me_load_hit_store &&
                  me_valid && (me_wb_rd != 5'd0);
  assign flush  = (state == FLUSH);

  always_ff @(posedge clock) begin
    if (commit)
      rf[me_wb_rd] <= me_wb_val;
  end

  // Reads see a same-edge write so forwarding needs no extra stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      rs1_val <= '0;
      rs2_val <= '0;
    end else begin
      if (rs1_addr == 5'd0)
        rs1_val <= '0;
      else if (commit && me_wb_rd == rs1_addr)
        rs1_val <= me_wb_val;
      else
        rs1_val <= rf[rs1_addr];
      if (rs2_addr == 5'd0)
        rs2_val <= '0;
      else if (commit && me_wb_rd == rs2_addr)
        rs2_val <= me_wb_val;
      else
        rs2_val <= rf[rs2_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RUN;
      fcnt       <= '0;
      restart    <= 1'b0;
      restart_pc <= RESET_PC;
      mepc       <= '0;
      mcause     <= '0;
      mtval      <= '0;
      minstret   <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_val     <= '0;
    end else begin
      restart  <= 1'b0;
      wb_valid <= 1'b0;
      case (state)
        RUN: begin
          if (me_exc_misaligned) begin
            mepc       <= me_pc;
            mcause     <= me_exc_store ? 32'd6 : 32'd4;
            mtval      <= me_exc_mtval;
            restart_pc <= MTVEC;
            restart    <= 1'b1;
            state      <= FLUSH;
            fcnt       <= FLOAD;
          end else if (me_load_hit_store) begin
            restart_pc <= me_pc;
            restart    <= 1'b1;
            state      <= FLUSH;
            fcnt       <= FLOAD;
          end else if (me_valid) begin
            minstret <= minstret + 64'd1;
            if (me_wb_rd != 5'd0) begin
              wb_valid <= 1'b1;
              wb_rd    <= me_wb_rd;
              wb_val   <= me_wb_val;
            end
          end
        end
        FLUSH: begin
          if (fcnt == '0)
            state <= RUN;
          else
            fcnt <= fcnt - 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
